// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: NOP encoding,
// default widths, the standard control bundle and the main-register source select.
package pipe_pkg;

  localparam logic [15:0] NOP_INST           = 16'h4000;
  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_CTRL_WIDTH = 4;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    SEL_IN,
    SEL_SKID,
    SEL_BUBBLE
  } main_sel_e;

endpackage

// File: rtl/pipe_reg_en.sv
// Enabled register with asynchronous active-high reset to a parametrised value;
// used for the payload and control halves of both stage entries.
module pipe_reg_en #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional one-entry skid buffer,
// bubble-inserting flush and a global freeze that overrides everything.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned      CTRL_WIDTH  = DEFAULT_CTRL_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE_DATA = WIDTH'(NOP_INST),
  parameter bit               SKID        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  logic                  outValid_q, outValid_d;
  logic                  skidValid_q, skidValid_d;
  logic                  accept, emit;
  logic                  mainEn, skidEn;
  main_sel_e             mainSel;
  logic [WIDTH-1:0]      mainData_d, mainData_q, skidData_q;
  logic [CTRL_WIDTH-1:0] mainCtrl_d, mainCtrl_q, skidCtrl_q;

  // With the skid buffer, ready depends only on registered state (plus hold);
  // without it, ready looks through to the downstream consumer.
  assign in_ready = ~rst & ~hold &
                    (SKID ? ~skidValid_q : (~outValid_q | out_ready));

  assign accept = in_valid & in_ready;
  assign emit   = outValid_q & out_ready & ~hold;

  always_comb begin
    outValid_d  = outValid_q;
    skidValid_d = skidValid_q;
    mainEn      = 1'b0;
    skidEn      = 1'b0;
    mainSel     = SEL_IN;
    if (!hold) begin
      if (flush) begin
        outValid_d  = 1'b0;
        skidValid_d = 1'b0;
        mainEn      = 1'b1;
        mainSel     = SEL_BUBBLE;
      end else if (skidValid_q) begin
        if (emit) begin
          mainEn      = 1'b1;
          mainSel     = SEL_SKID;
          skidValid_d = 1'b0;
        end
      end else if (accept && (!outValid_q || emit)) begin
        mainEn     = 1'b1;
        mainSel    = SEL_IN;
        outValid_d = 1'b1;
      end else if (accept) begin
        skidEn      = 1'b1;
        skidValid_d = 1'b1;
      end else if (emit) begin
        mainEn     = 1'b1;
        mainSel    = SEL_BUBBLE;
        outValid_d = 1'b0;
      end
    end
  end

  always_comb begin
    mainData_d = BUBBLE_DATA;
    mainCtrl_d = '0;
    case (mainSel)
      SEL_IN: begin
        mainData_d = in_data;
        mainCtrl_d = in_ctrl;
      end
      SEL_SKID: begin
        mainData_d = skidData_q;
        mainCtrl_d = skidCtrl_q;
      end
      default: begin
        mainData_d = BUBBLE_DATA;
        mainCtrl_d = '0;
      end
    endcase
  end

  // The skid valid bit is pinned low when the stage is built without a skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      outValid_q  <= outValid_d;
      skidValid_q <= SKID ? skidValid_d : 1'b0;
    end
  end

  pipe_reg_en #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_DATA)) uMainData (
    .clk(clk), .rst(rst), .en_i(mainEn), .d_i(mainData_d), .q_o(mainData_q)
  );

  pipe_reg_en #(.WIDTH(CTRL_WIDTH), .RESET_VAL('0)) uMainCtrl (
    .clk(clk), .rst(rst), .en_i(mainEn), .d_i(mainCtrl_d), .q_o(mainCtrl_q)
  );

  pipe_reg_en #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_DATA)) uSkidData (
    .clk(clk), .rst(rst), .en_i(skidEn), .d_i(in_data), .q_o(skidData_q)
  );

  pipe_reg_en #(.WIDTH(CTRL_WIDTH), .RESET_VAL('0)) uSkidCtrl (
    .clk(clk), .rst(rst), .en_i(skidEn), .d_i(in_ctrl), .q_o(skidCtrl_q)
  );

  assign out_valid = outValid_q;
  assign out_data  = mainData_q;
  assign out_ctrl  = outValid_q ? mainCtrl_q : '0;
  assign occupancy = {1'b0, outValid_q} + {1'b0, skidValid_q};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid (A) and a non-skid (B) instance share one
// input stream and are compared every cycle against queue-based models.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst, hold, flush, inValid, outReady;
  logic [15:0] inData;
  logic [3:0]  inCtrl;

  logic        aInReady, aOutValid, bInReady, bOutValid;
  logic [15:0] aOutData, bOutData;
  logic [3:0]  aOutCtrl, bOutCtrl;
  logic [1:0]  aOcc, bOcc;

  int compared   = 0;
  int mismatched = 0;

  // Each model entry is {ctrl, data}; A holds up to two beats, B up to one.
  logic [19:0] qA[$];
  logic [19:0] qB[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.SKID(1'b1)) dutA (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(inValid), .in_ready(aInReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(aOutValid), .out_ready(outReady), .out_data(aOutData),
    .out_ctrl(aOutCtrl), .occupancy(aOcc)
  );

  pipe_stage_elastic #(.SKID(1'b0)) dutB (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(inValid), .in_ready(bInReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(bOutValid), .out_ready(outReady), .out_data(bOutData),
    .out_ctrl(bOutCtrl), .occupancy(bOcc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelReadyA();
    return !rst && !hold && (qA.size() < 2);
  endfunction

  function automatic logic modelReadyB();
    return !rst && !hold && (qB.size() == 0 || outReady);
  endfunction

  task automatic compareModels();
    checkOutput("A in_ready",  32'(aInReady),  32'(modelReadyA()));
    checkOutput("A out_valid", 32'(aOutValid), 32'(qA.size() > 0));
    checkOutput("A out_data",  32'(aOutData),  (qA.size() > 0) ? 32'(qA[0][15:0]) : 32'h4000);
    checkOutput("A out_ctrl",  32'(aOutCtrl),  (qA.size() > 0) ? 32'(qA[0][19:16]) : 32'h0);
    checkOutput("A occupancy", 32'(aOcc),      32'(qA.size()));
    checkOutput("A ctrl gate", 32'(!aOutValid && aOutCtrl != 4'h0), 32'h0);
    checkOutput("B in_ready",  32'(bInReady),  32'(modelReadyB()));
    checkOutput("B out_valid", 32'(bOutValid), 32'(qB.size() > 0));
    checkOutput("B out_data",  32'(bOutData),  (qB.size() > 0) ? 32'(qB[0][15:0]) : 32'h4000);
    checkOutput("B out_ctrl",  32'(bOutCtrl),  (qB.size() > 0) ? 32'(qB[0][19:16]) : 32'h0);
    checkOutput("B occupancy", 32'(bOcc),      32'(qB.size()));
    checkOutput("B ctrl gate", 32'(!bOutValid && bOutCtrl != 4'h0), 32'h0);
  endtask

  // Advance a model queue by one edge: pop on emit, then push on accept; flush empties it.
  task automatic modelStep();
    logic accA, accB, emA, emB;
    accA = inValid && modelReadyA();
    accB = inValid && modelReadyB();
    emA  = (qA.size() > 0) && outReady && !hold;
    emB  = (qB.size() > 0) && outReady && !hold;
    if (!hold) begin
      if (flush) begin
        qA.delete();
        qB.delete();
      end else begin
        if (emA) void'(qA.pop_front());
        if (accA) qA.push_back({inCtrl, inData});
        if (emB) void'(qB.pop_front());
        if (accB) qB.push_back({inCtrl, inData});
      end
    end
  endtask

  // Drive one cycle of inputs just after an edge, check both DUTs, then cross the next edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] c,
                               input logic ordy, input logic h, input logic f);
    inValid  = v;
    inData   = d;
    inCtrl   = c;
    outReady = ordy;
    hold     = h;
    flush    = f;
    #1;
    compareModels();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inData = 16'h0; inCtrl = 4'h0;
    #2;
    compareModels();
    checkOutput("reset A in_ready", 32'(aInReady), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming through the skid stage at one beat per cycle.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream data", 32'(aOutData), 32'(i));
      checkOutput("stream occ",  32'(aOcc), 32'h1);
      checkOutput("stream rdy",  32'(aInReady), 32'h1);
    end
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream drained", 32'(aOutValid), 32'h0);

    // Backpressure fills the skid entry, then drains in order.
    applyStimulus(1'b1, 16'h0011, 4'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0022, 4'h2, 1'b0, 1'b0, 1'b0);
    checkOutput("bp occ full",  32'(aOcc), 32'h2);
    checkOutput("bp rdy low",   32'(aInReady), 32'h0);
    checkOutput("bp head",      32'(aOutData), 32'h0011);
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp second",    32'(aOutData), 32'h0022);
    checkOutput("bp rdy back",  32'(aInReady), 32'h1);
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp empty",     32'(aOutValid), 32'h0);

    // Flush with both entries occupied and a beat on the input.
    applyStimulus(1'b1, 16'h0055, 4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0066, 4'h6, 1'b0, 1'b0, 1'b0);
    checkOutput("pre-flush occ", 32'(aOcc), 32'h2);
    applyStimulus(1'b1, 16'h0033, 4'h3, 1'b0, 1'b0, 1'b1);
    checkOutput("flush valid", 32'(aOutValid), 32'h0);
    checkOutput("flush data",  32'(aOutData), 32'h4000);
    checkOutput("flush ctrl",  32'(aOutCtrl), 32'h0);
    checkOutput("flush occ",   32'(aOcc), 32'h0);
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush no ghost", 32'(aOutValid), 32'h0);

    // Hold dominates a simultaneous flush and blocks emits and accepts.
    applyStimulus(1'b1, 16'h0044, 4'b1011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0099, 4'h9, 1'b1, 1'b1, 1'b1);
      checkOutput("hold data",  32'(aOutData), 32'h0044);
      checkOutput("hold ctrl",  32'(aOutCtrl), 32'hB);
      checkOutput("hold rdy",   32'(aInReady), 32'h0);
      checkOutput("hold occ",   32'(aOcc), 32'h1);
    end
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("post-hold empty", 32'(aOutValid), 32'h0);

    // Non-skid stage passes ready straight through from downstream.
    applyStimulus(1'b1, 16'h0071, 4'h7, 1'b0, 1'b0, 1'b0);
    inValid = 1'b1; inData = 16'h0072; inCtrl = 4'h8; outReady = 1'b1;
    #1;
    checkOutput("B comb ready", 32'(bInReady), 32'h1);
    applyStimulus(1'b1, 16'h0072, 4'h8, 1'b1, 1'b0, 1'b0);
    checkOutput("B replace data",  32'(bOutData), 32'h0072);
    checkOutput("B replace valid", 32'(bOutValid), 32'h1);
    outReady = 1'b0;
    #1;
    checkOutput("B ready blocked", 32'(bInReady), 32'h0);
    applyStimulus(1'b1, 16'h0073, 4'h3, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges clears both stages immediately.
    #2;
    rst = 1'b1;
    #1;
    qA.delete();
    qB.delete();
    checkOutput("async valid", 32'(aOutValid), 32'h0);
    checkOutput("async data",  32'(aOutData), 32'h4000);
    checkOutput("async ctrl",  32'(aOutCtrl), 32'h0);
    checkOutput("async occ",   32'(aOcc), 32'h0);
    checkOutput("async B occ", 32'(bOcc), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("after reset empty", 32'(aOutValid), 32'h0);

    // Randomised traffic against the queue models.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0);
    end
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
